// File: rtl/scan_risk_loader.sv
`default_nettype none
// ============================================================================
// Module   : scan_risk_loader
// Brief    : Collects up to eight position beats per portfolio, holds them
//            stable for the risk core, then captures the scanning-risk result.
// Revision : 1.0 - initial release
// ============================================================================
module scan_risk_loader #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_index,
    input  logic [7:0]  in_pos,
    input  logic [15:0] in_range,
    input  logic        in_last,
    output logic [2:0]  numberOfIntrument,
    output logic [15:0] PriceScanRange,
    output logic [7:0]  pos0,
    output logic [7:0]  pos1,
    output logic [7:0]  pos2,
    output logic [7:0]  pos3,
    output logic [7:0]  pos4,
    output logic [7:0]  pos5,
    output logic [7:0]  pos6,
    output logic [7:0]  pos7,
    input  logic [31:0] scanningRisk,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_risk,
    output logic        res_ovf
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_SETTLE = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    localparam logic [3:0] c_settle_last = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] c_count_max   = 4'd8;

    state_t      r_state;
    logic [7:0]  r_pos [0:7];
    logic [15:0] r_range;
    logic [3:0]  r_count;
    logic        r_ovf;
    logic [3:0]  r_settle;
    logic [31:0] r_risk;
    logic        r_res_ovf;
    logic        r_res_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            for (int i = 0; i < 8; i++) r_pos[i] <= '0;
            r_range     <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_settle    <= '0;
            r_risk      <= '0;
            r_res_ovf   <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        // Later assignment to the addressed slot wins over the clear.
                        for (int i = 0; i < 8; i++) r_pos[i] <= '0;
                        r_pos[in_index] <= in_pos;
                        r_range         <= in_range;
                        r_count         <= 4'd1;
                        r_ovf           <= 1'b0;
                        r_settle        <= '0;
                        r_state         <= in_last ? S_SETTLE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        r_pos[in_index] <= in_pos;
                        if (r_count == c_count_max) r_ovf <= 1'b1;
                        else                        r_count <= r_count + 4'd1;
                        r_settle <= '0;
                        if (in_last) r_state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_settle == c_settle_last) begin
                        r_risk      <= scanningRisk;
                        r_res_ovf   <= r_ovf;
                        r_res_valid <= 1'b1;
                        r_state     <= S_RESULT;
                    end else begin
                        r_settle <= r_settle + 4'd1;
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready          = (r_state == S_IDLE) || (r_state == S_LOAD);
    // Count saturates at 8, so count-1 never exceeds 7.
    assign numberOfIntrument = (r_count == 4'd0) ? 3'd0 : 3'(r_count - 4'd1);
    assign PriceScanRange    = r_range;
    assign pos0              = r_pos[0];
    assign pos1              = r_pos[1];
    assign pos2              = r_pos[2];
    assign pos3              = r_pos[3];
    assign pos4              = r_pos[4];
    assign pos5              = r_pos[5];
    assign pos6              = r_pos[6];
    assign pos7              = r_pos[7];
    assign res_valid         = r_res_valid;
    assign res_risk          = r_risk;
    assign res_ovf           = r_res_ovf;

endmodule
`default_nettype wire

// File: tb/tb_scan_risk_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_scan_risk_loader
// Brief    : Directed self-checking bench for scan_risk_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scan_risk_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_index;
    logic [7:0]  in_pos;
    logic [15:0] in_range;
    logic        in_last;
    logic [2:0]  numberOfIntrument;
    logic [15:0] PriceScanRange;
    logic [7:0]  pos [0:7];
    logic [31:0] scanningRisk;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_risk;
    logic        res_ovf;

    int checks = 0;
    int errors = 0;

    scan_risk_loader #(.SETTLE_CYCLES(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_index          (in_index),
        .in_pos            (in_pos),
        .in_range          (in_range),
        .in_last           (in_last),
        .numberOfIntrument (numberOfIntrument),
        .PriceScanRange    (PriceScanRange),
        .pos0              (pos[0]),
        .pos1              (pos[1]),
        .pos2              (pos[2]),
        .pos3              (pos[3]),
        .pos4              (pos[4]),
        .pos5              (pos[5]),
        .pos6              (pos[6]),
        .pos7              (pos[7]),
        .scanningRisk      (scanningRisk),
        .res_valid         (res_valid),
        .res_ready         (res_ready),
        .res_risk          (res_risk),
        .res_ovf           (res_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] idx, input logic [7:0] p,
                        input logic [15:0] rng, input logic last);
        in_valid = 1'b1;
        in_index = idx;
        in_pos   = p;
        in_range = rng;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_result();
        int n;
        n = 0;
        while (res_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("result_timeout", 32'(res_valid), 32'd1);
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("hs_valid_low", 32'(res_valid), 32'd0);
        chk("hs_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        reset        = 1'b1;
        in_valid     = 1'b0;
        in_index     = '0;
        in_pos       = '0;
        in_range     = '0;
        in_last      = 1'b0;
        scanningRisk = '0;
        res_ready    = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_risk", res_risk, 32'd0);
        chk("rst_range", 32'(PriceScanRange), 32'd0);
        chk("rst_noi", 32'(numberOfIntrument), 32'd0);
        reset = 1'b0;
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Single-beat portfolio, latency SETTLE_CYCLES+1
        scanningRisk = 32'h0000_1234;
        send(3'd3, 8'd5, 16'h0100, 1'b1);
        chk("s1_in_ready", 32'(in_ready), 32'd0);
        chk("s1_pos3", 32'(pos[3]), 32'd5);
        chk("s1_pos0", 32'(pos[0]), 32'd0);
        chk("s1_pos7", 32'(pos[7]), 32'd0);
        chk("s1_noi", 32'(numberOfIntrument), 32'd0);
        chk("s1_range", 32'(PriceScanRange), 32'h0100);
        chk("s1_valid_e1", 32'(res_valid), 32'd0);
        tick();
        chk("s1_valid_e2", 32'(res_valid), 32'd0);
        tick();
        chk("s1_valid_e3", 32'(res_valid), 32'd1);
        chk("s1_risk", res_risk, 32'h0000_1234);
        chk("s1_ovf", 32'(res_ovf), 32'd0);
        handshake();
        chk("s1_risk_held", res_risk, 32'h0000_1234);

        // Eight beats fill every slot
        for (int i = 0; i < 8; i++)
            send(3'(i), 8'(i + 1), (i == 0) ? 16'h0010 : 16'h0000, i == 7);
        for (int i = 0; i < 8; i++)
            chk($sformatf("s8_pos%0d", i), 32'(pos[i]), 32'(i + 1));
        chk("s8_noi", 32'(numberOfIntrument), 32'd7);
        chk("s8_range", 32'(PriceScanRange), 32'h0010);
        scanningRisk = 32'hAAAA_5555;
        wait_result();
        chk("s8_risk", res_risk, 32'hAAAA_5555);
        chk("s8_ovf", 32'(res_ovf), 32'd0);
        handshake();

        // Ten beats on slot 2: overflow, last write wins
        for (int i = 1; i <= 10; i++)
            send(3'd2, 8'(i), 16'h0020, i == 10);
        chk("ov_pos2", 32'(pos[2]), 32'd10);
        chk("ov_pos0", 32'(pos[0]), 32'd0);
        chk("ov_noi", 32'(numberOfIntrument), 32'd7);
        scanningRisk = 32'h0000_0042;
        wait_result();
        chk("ov_ovf", 32'(res_ovf), 32'd1);
        chk("ov_risk", res_risk, 32'h0000_0042);

        // Back-pressure: result held, no beats taken in RESULT
        in_valid = 1'b1;
        in_index = 3'd0;
        in_pos   = 8'h77;
        in_range = 16'h0ABC;
        for (int i = 0; i < 5; i++) begin
            scanningRisk = 32'h1000_0000 + 32'(i);
            tick();
            chk("bp_valid", 32'(res_valid), 32'd1);
            chk("bp_risk", res_risk, 32'h0000_0042);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        in_valid  = 1'b0;
        chk("bp_hs_valid", 32'(res_valid), 32'd0);
        chk("bp_hs_in_ready", 32'(in_ready), 32'd1);
        chk("bp_no_accept_pos0", 32'(pos[0]), 32'd0);
        chk("bp_no_accept_range", 32'(PriceScanRange), 32'h0020);

        // Asynchronous reset in the middle of LOAD
        send(3'd1, 8'd9, 16'h0300, 1'b0);
        send(3'd2, 8'd8, 16'h0000, 1'b0);
        send(3'd3, 8'd7, 16'h0000, 1'b0);
        chk("mr_noi_pre", 32'(numberOfIntrument), 32'd2);
        chk("mr_range_pre", 32'(PriceScanRange), 32'h0300);
        reset = 1'b1;
        #1;
        chk("mr_pos1", 32'(pos[1]), 32'd0);
        chk("mr_pos3", 32'(pos[3]), 32'd0);
        chk("mr_range", 32'(PriceScanRange), 32'd0);
        chk("mr_noi", 32'(numberOfIntrument), 32'd0);
        chk("mr_risk", res_risk, 32'd0);
        chk("mr_ovf", 32'(res_ovf), 32'd0);
        chk("mr_in_ready", 32'(in_ready), 32'd1);
        tick();
        reset = 1'b0;
        send(3'd0, 8'd7, 16'h0400, 1'b1);
        chk("mr_new_pos0", 32'(pos[0]), 32'd7);
        for (int i = 1; i < 8; i++)
            chk($sformatf("mr_new_pos%0d", i), 32'(pos[i]), 32'd0);
        chk("mr_new_noi", 32'(numberOfIntrument), 32'd0);
        wait_result();
        handshake();

        // in_range only taken on first beat; new portfolio clears slots
        send(3'd4, 8'h11, 16'h0100, 1'b0);
        send(3'd5, 8'h22, 16'hFFFF, 1'b1);
        chk("rg_a_range", 32'(PriceScanRange), 32'h0100);
        wait_result();
        handshake();
        send(3'd6, 8'h33, 16'h0200, 1'b0);
        send(3'd7, 8'h44, 16'hFFFF, 1'b1);
        chk("rg_b_range", 32'(PriceScanRange), 32'h0200);
        chk("rg_b_pos4", 32'(pos[4]), 32'd0);
        chk("rg_b_pos5", 32'(pos[5]), 32'd0);
        chk("rg_b_pos6", 32'(pos[6]), 32'h33);
        chk("rg_b_pos7", 32'(pos[7]), 32'h44);
        chk("rg_b_noi", 32'(numberOfIntrument), 32'd1);
        wait_result();
        handshake();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
